regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-read-port integer register file with write-to-read bypass and a per-register pending-write scoreboard. Sits in the decode stage of the 5-stage pipeline: decode reads operands and queries `busy` for hazard stalls, issue marks destinations pending, and writeback writes data and clears the pending mark. Successor to the fixed 2-read/1-write negedge register file.

## Interface
Parameters:
- `XLEN`, default 32: data width.
- `NREGS`, default 32: register count, power of two, ≥ 2. `AW = $clog2(NREGS)`.
- `NREAD`, default 2: number of read ports, 1..4.
- `BYPASS`, default 1: 1 forwards same-cycle write data to reads; 0 gives no forwarding.
- `ZERO_REG`, default 1: 1 hardwires register 0 to zero and never marks it pending.

Ports:
- `clk_i` input 1: clock, all state on the rising edge.
- `rst_ni` input 1: asynchronous active-low reset.
- `we_i` input 1: writeback enable.
- `waddr_i` input AW: writeback register.
- `wdata_i` input XLEN: writeback data.
- `raddr_i` input NREAD×AW: read addresses.
- `rdata_o` output NREAD×XLEN: read data, combinational.
- `busy_o` output NREAD: the read register has an outstanding write, combinational.
- `issue_i` input 1: an instruction with a destination register issues this cycle.
- `issue_addr_i` input AW: destination of the issuing instruction.
- `flush_i` input 1: pipeline flush; clears all pending marks.
- `pending_o` output NREGS: raw scoreboard vector, for debug and verification.

## Operation
- Storage: `NREGS` × `XLEN` data array and an `NREGS`-bit pending vector.
- Reset (`rst_ni` = 0, any time, asynchronous): every data entry = 0 and pending = 0. Outputs follow combinationally: `rdata_o` = 0, `busy_o` = 0, `pending_o` = 0.
- Write: on a rising edge with `we_i` = 1, `rf[waddr_i] <= wdata_i`. When `ZERO_REG` = 1 and `waddr_i` = 0, the write is dropped.
- Read port k:
  - When `ZERO_REG` = 1 and `raddr_i[k]` = 0, output 0.
  - Else when `BYPASS` = 1, `we_i` = 1 and `waddr_i` = `raddr_i[k]`, output `wdata_i`.
  - Else output `rf[raddr_i[k]]`.
- Scoreboard next state, highest priority first:
  1. `flush_i` = 1: all pending bits are cleared. A concurrent issue is discarded. A concurrent write still updates data.
  2. `issue_i` = 1: the bit for `issue_addr_i` is set. This overrides a concurrent clear of the same address, because the new producer supersedes the old.
  3. `we_i` = 1: the bit for `waddr_i` is cleared.
- Issue and write on different addresses both take effect in the same cycle.
- Issuing to an already-pending register (WAW) leaves the bit set; the first writeback clears it. The pipeline guarantees in-order writeback.
- With `ZERO_REG` = 1, bit 0 is held at 0.
- `busy_o[k]` = `pending[raddr_i[k]]` AND NOT (`BYPASS` AND `we_i` AND `waddr_i` == `raddr_i[k]`). It is forced to 0 for address 0 when `ZERO_REG` = 1.
- An address ≥ `NREGS` cannot occur because `NREGS` is a power of two.

## Timing
- Reads: zero-cycle combinational path from `raddr_i` to `rdata_o` and `busy_o`.
- Writes without bypass: data is visible one cycle after `we_i`.
- Writes with `BYPASS` = 1: data is visible in the same cycle on `rdata_o`, and the same cycle's `busy_o` drops.
- Scoreboard updates land on the rising edge. `busy_o` reflects an issue from cycle N starting in cycle N+1.
- Reset release: the first edge with `rst_ni` = 1 may write. No recovery cycles are required.
- Combinational paths run from `we_i`, `waddr_i` and `wdata_i` to `rdata_o`/`busy_o` only when `BYPASS` = 1.

## Structure
- `regfile_pkg` holds the default `XLEN`, `NREGS` and `NREAD` values and the derived `AW`. It also holds the typedefs `reg_addr_t` (`AW` bits) and `xlen_t` (`XLEN` bits), shared with decode and writeback.
- Sub-module `regfile_scoreboard`:
  - Contains the pending vector, the priority logic, `NREAD` busy lookups and the `pending_o` output.
  - The top level instantiates it alongside the data array and the read/bypass muxes.

## Test plan
- **Reset:**
  - Stimulus: write 0xDEADBEEF to x5, then assert `rst_ni` = 0 mid-cycle.
  - Required: `rdata_o` for x5 reads 0 immediately, without waiting for a clock edge, and `pending_o` = 0.
- **Zero register:**
  - Stimulus: `we_i` with x0 ← 0x1234, and issue to x0.
  - Required: x0 reads 0 and `busy_o` = 0 both in the same cycle and on the next.
- **Bypass:**
  - Stimulus: with `BYPASS` = 1, write x7 ← 0xA5A5A5A5 while port 1 reads x7.
  - Required: `rdata_o[1]` = 0xA5A5A5A5 in the same cycle.
  - Stimulus: repeat with `BYPASS` = 0.
  - Required: the old value is seen in the same cycle and 0xA5A5A5A5 in the next cycle.
- **Scoreboard:**
  - Stimulus: issue x3 in cycle 0.
  - Required: `busy_o` for x3 is 1 in cycles 1–2.
  - Stimulus: write x3 in cycle 3.
  - Required: `busy_o` = 0 in cycle 3 (with bypass) and `pending_o[3]` = 0 in cycle 4.
- **Simultaneous events:**
  - Stimulus: in one cycle, issue x9 and write x9.
  - Required: `pending_o[9]` = 1 next cycle.
  - Stimulus: in one cycle, flush, issue x4, and write x4 ← 0x55.
  - Required: `pending_o` = 0 and x4 = 0x55.
- **Parametrisation:**
  - Stimulus: `NREGS` = 16, `NREAD` = 3, `XLEN` = 64, with random write, issue and read traffic against a reference model for 10k cycles.
  - Required: zero mismatches.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the integer register file and its users
// (decode, writeback).
package regfile_pkg;

  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_NREGS = 32;
  localparam int unsigned RF_NREAD = 2;
  localparam int unsigned RF_AW    = $clog2(RF_NREGS);

  typedef logic [RF_AW-1:0]   reg_addr_t;
  typedef logic [RF_XLEN-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue and cleared at
// writeback, with a combinational busy lookup per read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = RF_NREGS,
  parameter int unsigned NREAD    = RF_NREAD,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      we_i,
  input  logic [AW-1:0]             waddr_i,
  input  logic                      issue_i,
  input  logic [AW-1:0]             issue_addr_i,
  input  logic                      flush_i,
  input  logic [NREAD-1:0][AW-1:0]  raddr_i,
  output logic [NREAD-1:0]          busy_o,
  output logic [NREGS-1:0]          pending_o
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // Next pending vector: flush beats issue, and issue beats the writeback
  // clear so a new producer of the same register stays tracked.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else begin
      if (we_i)    pending_d[waddr_i]      = 1'b0;
      if (issue_i) pending_d[issue_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) pending_d[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  // Busy lookup; a same-cycle forwarded write satisfies the reader.
  always_comb begin
    busy_o = '0;
    for (int k = 0; k < int'(NREAD); k++) begin
      busy_o[k] = pending_q[raddr_i[k]] &&
                  !((BYPASS != 0) && we_i && (waddr_i == raddr_i[k]));
      if ((ZERO_REG != 0) && (raddr_i[k] == '0)) busy_o[k] = 1'b0;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with optional write-to-read bypass and a
// pending-write scoreboard for decode-stage hazard detection.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = RF_XLEN,
  parameter int unsigned NREGS    = RF_NREGS,
  parameter int unsigned NREAD    = RF_NREAD,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [AW-1:0]              waddr_i,
  input  logic [XLEN-1:0]            wdata_i,
  input  logic [NREAD-1:0][AW-1:0]   raddr_i,
  output logic [NREAD-1:0][XLEN-1:0] rdata_o,
  output logic [NREAD-1:0]           busy_o,
  input  logic                       issue_i,
  input  logic [AW-1:0]              issue_addr_i,
  input  logic                       flush_i,
  output logic [NREGS-1:0]           pending_o
);

  logic [XLEN-1:0] rf_q [NREGS];
  logic            wr_en;

  assign wr_en = we_i && !((ZERO_REG != 0) && (waddr_i == '0));

  // Data array; writes to x0 are dropped when it is hardwired.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  // Read muxes: hardwired zero, then forwarded write data, then the array.
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < int'(NREAD); k++) begin
      if ((ZERO_REG != 0) && (raddr_i[k] == '0))
        rdata_o[k] = '0;
      else if ((BYPASS != 0) && we_i && (waddr_i == raddr_i[k]))
        rdata_o[k] = wdata_i;
      else
        rdata_o[k] = rf_q[raddr_i[k]];
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NREAD    (NREAD),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .issue_i      (issue_i),
    .issue_addr_i (issue_addr_i),
    .flush_i      (flush_i),
    .raddr_i      (raddr_i),
    .busy_o       (busy_o),
    .pending_o    (pending_o)
  );

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic clk;
  logic rst_ni;

  // instance a: defaults (bypass on); b: bypass off; c: 16 regs, 3 ports, 64 bit
  logic             we_a, issue_a, flush_a;
  logic [4:0]       waddr_a, issue_addr_a;
  logic [31:0]      wdata_a;
  logic [1:0][4:0]  raddr_a;
  logic [1:0][31:0] rdata_a;
  logic [1:0]       busy_a;
  logic [31:0]      pending_a;

  logic             we_b, issue_b, flush_b;
  logic [4:0]       waddr_b, issue_addr_b;
  logic [31:0]      wdata_b;
  logic [1:0][4:0]  raddr_b;
  logic [1:0][31:0] rdata_b;
  logic [1:0]       busy_b;
  logic [31:0]      pending_b;

  logic             we_c, issue_c, flush_c;
  logic [3:0]       waddr_c, issue_addr_c;
  logic [63:0]      wdata_c;
  logic [2:0][3:0]  raddr_c;
  logic [2:0][63:0] rdata_c;
  logic [2:0]       busy_c;
  logic [15:0]      pending_c;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .we_i(we_a), .waddr_i(waddr_a), .wdata_i(wdata_a),
    .raddr_i(raddr_a), .rdata_o(rdata_a), .busy_o(busy_a), .issue_i(issue_a),
    .issue_addr_i(issue_addr_a), .flush_i(flush_a), .pending_o(pending_a));

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .we_i(we_b), .waddr_i(waddr_b), .wdata_i(wdata_b),
    .raddr_i(raddr_b), .rdata_o(rdata_b), .busy_o(busy_b), .issue_i(issue_b),
    .issue_addr_i(issue_addr_b), .flush_i(flush_b), .pending_o(pending_b));

  regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(3), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_ni), .we_i(we_c), .waddr_i(waddr_c), .wdata_i(wdata_c),
    .raddr_i(raddr_c), .rdata_o(rdata_c), .busy_o(busy_c), .issue_i(issue_c),
    .issue_addr_i(issue_addr_c), .flush_i(flush_c), .pending_o(pending_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_nregs(int i);
    return (i == 2) ? 16 : 32;
  endfunction
  function automatic int cfg_nread(int i);
    return (i == 2) ? 3 : 2;
  endfunction
  function automatic bit cfg_bypass(int i);
    return (i != 1);
  endfunction

  // generic views of all three instances
  bit        g_we [3];
  bit        g_issue [3];
  bit        g_flush [3];
  int        g_waddr [3];
  int        g_iaddr [3];
  bit [63:0] g_wdata [3];
  int        g_raddr [3][4];
  bit [63:0] g_rdata [3][4];
  bit        g_busy [3][4];
  bit [31:0] g_pend [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      g_we[i] = 1'b0; g_issue[i] = 1'b0; g_flush[i] = 1'b0;
      g_waddr[i] = 0; g_iaddr[i] = 0; g_wdata[i] = '0; g_pend[i] = '0;
      for (int k = 0; k < 4; k++) begin
        g_raddr[i][k] = 0; g_rdata[i][k] = '0; g_busy[i][k] = 1'b0;
      end
    end
    g_we[0] = we_a; g_issue[0] = issue_a; g_flush[0] = flush_a;
    g_waddr[0] = int'(waddr_a); g_iaddr[0] = int'(issue_addr_a);
    g_wdata[0] = {32'd0, wdata_a}; g_pend[0] = pending_a;
    g_we[1] = we_b; g_issue[1] = issue_b; g_flush[1] = flush_b;
    g_waddr[1] = int'(waddr_b); g_iaddr[1] = int'(issue_addr_b);
    g_wdata[1] = {32'd0, wdata_b}; g_pend[1] = pending_b;
    g_we[2] = we_c; g_issue[2] = issue_c; g_flush[2] = flush_c;
    g_waddr[2] = int'(waddr_c); g_iaddr[2] = int'(issue_addr_c);
    g_wdata[2] = wdata_c; g_pend[2] = {16'd0, pending_c};
    for (int k = 0; k < 2; k++) begin
      g_raddr[0][k] = int'(raddr_a[k]); g_rdata[0][k] = {32'd0, rdata_a[k]}; g_busy[0][k] = busy_a[k];
      g_raddr[1][k] = int'(raddr_b[k]); g_rdata[1][k] = {32'd0, rdata_b[k]}; g_busy[1][k] = busy_b[k];
    end
    for (int k = 0; k < 3; k++) begin
      g_raddr[2][k] = int'(raddr_c[k]); g_rdata[2][k] = rdata_c[k]; g_busy[2][k] = busy_c[k];
    end
  end

  // reference model: plain arrays of register contents and pending flags
  bit [63:0] m_rf [3][32];
  bit        m_pend [3][32];

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 3; i++)
        for (int r = 0; r < 32; r++) begin
          m_rf[i][r] = '0;
          m_pend[i][r] = 1'b0;
        end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (g_we[i] && g_waddr[i] != 0) m_rf[i][g_waddr[i]] = g_wdata[i];
        if (g_flush[i]) begin
          for (int r = 0; r < 32; r++) m_pend[i][r] = 1'b0;
        end else begin
          if (g_we[i])    m_pend[i][g_waddr[i]] = 1'b0;
          if (g_issue[i]) m_pend[i][g_iaddr[i]] = 1'b1;
        end
        m_pend[i][0] = 1'b0;
      end
    end
  end

  task automatic check(input string nm, input int inst, input int port,
                       input bit [63:0] act, input bit [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d port%0d t=%0t: got %h expected %h",
               nm, inst, port, $time, act, exp);
    end
  endtask

  // per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit [31:0] exp_p;
      exp_p = '0;
      for (int r = 0; r < cfg_nregs(i); r++) exp_p[r] = m_pend[i][r];
      check("pending", i, 0, {32'd0, g_pend[i]}, {32'd0, exp_p});
      for (int k = 0; k < cfg_nread(i); k++) begin
        int        a;
        bit        hit;
        bit [63:0] exp_d;
        bit        exp_b;
        a = g_raddr[i][k];
        hit = cfg_bypass(i) && g_we[i] && (g_waddr[i] == a);
        if (a == 0)   exp_d = '0;
        else if (hit) exp_d = g_wdata[i];
        else          exp_d = m_rf[i][a];
        exp_b = (a != 0) && m_pend[i][a] && !hit;
        check("rdata", i, k, g_rdata[i][k], exp_d);
        check("busy", i, k, {63'd0, g_busy[i][k]}, {63'd0, exp_b});
      end
    end
  end

  task automatic idle_all();
    we_a = 0; issue_a = 0; flush_a = 0; waddr_a = 0; issue_addr_a = 0; wdata_a = 0; raddr_a = '0;
    we_b = 0; issue_b = 0; flush_b = 0; waddr_b = 0; issue_addr_b = 0; wdata_b = 0; raddr_b = '0;
    we_c = 0; issue_c = 0; flush_c = 0; waddr_c = 0; issue_addr_c = 0; wdata_c = 0; raddr_c = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    // reset state
    raddr_a[0] = 5'd5;
    #1 check("rst_rdata", 0, 0, {32'd0, rdata_a[0]}, 64'd0);
    check("rst_pending", 0, 0, {32'd0, pending_a}, 64'd0);

    // write x5, issue x6, then asynchronous reset mid-cycle
    we_a = 1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; issue_a = 1; issue_addr_a = 5'd6;
    step();
    we_a = 0; issue_a = 0;
    #1 check("wr_x5", 0, 0, {32'd0, rdata_a[0]}, 64'h0000_0000_DEAD_BEEF);
    check("pend_x6", 0, 0, {32'd0, pending_a}, 64'h40);
    rst_ni = 1'b0;
    #1 check("async_rst_rdata", 0, 0, {32'd0, rdata_a[0]}, 64'd0);
    check("async_rst_pending", 0, 0, {32'd0, pending_a}, 64'd0);
    step();
    rst_ni = 1'b1;

    // zero register
    we_a = 1; waddr_a = 5'd0; wdata_a = 32'h1234; issue_a = 1; issue_addr_a = 5'd0;
    raddr_a[0] = 5'd0; raddr_a[1] = 5'd0;
    #1 check("x0_rdata_same", 0, 0, {32'd0, rdata_a[0]}, 64'd0);
    check("x0_busy_same", 0, 0, {62'd0, busy_a}, 64'd0);
    step();
    we_a = 0; issue_a = 0;
    #1 check("x0_rdata_next", 0, 1, {32'd0, rdata_a[1]}, 64'd0);
    check("x0_busy_next", 0, 0, {62'd0, busy_a}, 64'd0);
    check("x0_pending", 0, 0, {32'd0, pending_a}, 64'd0);

    // bypass on
    we_a = 1; waddr_a = 5'd7; wdata_a = 32'hA5A5A5A5; raddr_a[1] = 5'd7;
    #1 check("bypass_on", 0, 1, {32'd0, rdata_a[1]}, 64'h0000_0000_A5A5_A5A5);
    step();
    we_a = 0;

    // bypass off: old value this cycle, new value next cycle
    we_b = 1; waddr_b = 5'd7; wdata_b = 32'h11111111;
    step();
    wdata_b = 32'hA5A5A5A5; raddr_b[1] = 5'd7;
    #1 check("bypass_off_old", 1, 1, {32'd0, rdata_b[1]}, 64'h0000_0000_1111_1111);
    step();
    we_b = 0;
    #1 check("bypass_off_new", 1, 1, {32'd0, rdata_b[1]}, 64'h0000_0000_A5A5_A5A5);

    // scoreboard: issue x3 in cycle 0, write it in cycle 3
    raddr_a[0] = 5'd3; issue_a = 1; issue_addr_a = 5'd3;
    step();
    issue_a = 0;
    #1 check("sb_busy_c1", 0, 0, {63'd0, busy_a[0]}, 64'd1);
    step();
    #1 check("sb_busy_c2", 0, 0, {63'd0, busy_a[0]}, 64'd1);
    step();
    we_a = 1; waddr_a = 5'd3; wdata_a = 32'h33;
    #1 check("sb_busy_c3", 0, 0, {63'd0, busy_a[0]}, 64'd0);
    check("sb_pend_c3", 0, 0, {63'd0, pending_a[3]}, 64'd1);
    step();
    we_a = 0;
    #1 check("sb_pend_c4", 0, 0, {63'd0, pending_a[3]}, 64'd0);
    check("sb_data_c4", 0, 0, {32'd0, rdata_a[0]}, 64'h33);

    // issue and write the same register
    issue_a = 1; issue_addr_a = 5'd9; we_a = 1; waddr_a = 5'd9; wdata_a = 32'h99;
    step();
    issue_a = 0; we_a = 0;
    #1 check("issue_wins", 0, 0, {63'd0, pending_a[9]}, 64'd1);

    // flush with issue and write
    flush_a = 1; issue_a = 1; issue_addr_a = 5'd4; we_a = 1; waddr_a = 5'd4; wdata_a = 32'h55;
    raddr_a[0] = 5'd4;
    step();
    flush_a = 0; issue_a = 0; we_a = 0;
    #1 check("flush_pending", 0, 0, {32'd0, pending_a}, 64'd0);
    check("flush_data", 0, 0, {32'd0, rdata_a[0]}, 64'h55);

    // random traffic on all instances, checked every cycle by the model
    for (int n = 0; n < 10000; n++) begin
      step();
      we_a = 1'($urandom_range(0, 1)); waddr_a = 5'($urandom_range(0, 31)); wdata_a = $urandom;
      issue_a = ($urandom_range(0, 2) == 0); issue_addr_a = 5'($urandom_range(0, 31));
      flush_a = ($urandom_range(0, 31) == 0);
      for (int k = 0; k < 2; k++)
        raddr_a[k] = ($urandom_range(0, 3) == 0) ? waddr_a : 5'($urandom_range(0, 31));
      we_b = 1'($urandom_range(0, 1)); waddr_b = 5'($urandom_range(0, 31)); wdata_b = $urandom;
      issue_b = ($urandom_range(0, 2) == 0); issue_addr_b = 5'($urandom_range(0, 31));
      flush_b = ($urandom_range(0, 31) == 0);
      for (int k = 0; k < 2; k++)
        raddr_b[k] = ($urandom_range(0, 3) == 0) ? waddr_b : 5'($urandom_range(0, 31));
      we_c = 1'($urandom_range(0, 1)); waddr_c = 4'($urandom_range(0, 15));
      wdata_c = {$urandom, $urandom};
      issue_c = ($urandom_range(0, 2) == 0); issue_addr_c = 4'($urandom_range(0, 15));
      flush_c = ($urandom_range(0, 31) == 0);
      for (int k = 0; k < 3; k++)
        raddr_c[k] = ($urandom_range(0, 3) == 0) ? waddr_c : 4'($urandom_range(0, 15));
    end

    step();
    idle_all();
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
